// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction field positions and decode types for the mips32 pipeline.
package mips32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RAW    = 5;
    localparam int unsigned OPW    = 6;

    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    localparam logic [OPW-1:0] OP_ADD   = 6'h00;
    localparam logic [OPW-1:0] OP_SUB   = 6'h01;
    localparam logic [OPW-1:0] OP_AND   = 6'h02;
    localparam logic [OPW-1:0] OP_OR    = 6'h03;
    localparam logic [OPW-1:0] OP_SLT   = 6'h04;
    localparam logic [OPW-1:0] OP_MUL   = 6'h05;
    localparam logic [OPW-1:0] OP_LW    = 6'h08;
    localparam logic [OPW-1:0] OP_SW    = 6'h09;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h0A;
    localparam logic [OPW-1:0] OP_SUBI  = 6'h0B;
    localparam logic [OPW-1:0] OP_SLTI  = 6'h0C;
    localparam logic [OPW-1:0] OP_BNEQZ = 6'h0D;
    localparam logic [OPW-1:0] OP_BEQZ  = 6'h0E;
    localparam logic [OPW-1:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_t;

    typedef enum logic [1:0] {FWD_ID, FWD_MEM, FWD_WB} fwd_sel_t;

    // Classify an opcode; MUL degrades to NOP when the multiplier is not built.
    function automatic instr_t decode_type(input logic [OPW-1:0] op, input bit mul_en);
        instr_t t;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: t = RR_ALU;
            OP_MUL:                                t = mul_en ? RR_ALU : NOP;
            OP_LW:                                 t = LOAD;
            OP_SW:                                 t = STORE;
            OP_ADDI, OP_SUBI, OP_SLTI:             t = RM_ALU;
            OP_BNEQZ, OP_BEQZ:                     t = BRANCH;
            OP_HLT:                                t = HALT;
            default:                               t = NOP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_hazard_unit.sv
// Combinational hazard logic: EX operand bypass selects, ID stall, EX bubble and halt detection.
module mips32_hazard_unit
    import mips32_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic           id_v,
    input  instr_t         id_t,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           ex_we,
    input  logic           ex_load,
    input  logic [RAW-1:0] ex_dst,
    input  logic [RAW-1:0] ex_rs,
    input  logic [RAW-1:0] ex_rt,
    input  logic           ex_taken,
    input  logic           mem_we,
    input  logic [RAW-1:0] mem_dst,
    input  logic           wb_we,
    input  logic [RAW-1:0] wb_dst,
    output fwd_sel_t       fwd_a_c,
    output fwd_sel_t       fwd_b_c,
    output logic           stall_c,
    output logic           bubble_ex_c,
    output logic           halt_id_c
);

    logic use_rs;
    logic use_rt;
    logic dep_ex;
    logic dep_mem;

    // Dependency checks against older in-flight writers and resulting pipeline controls.
    always_comb begin
        use_rs      = id_t inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
        use_rt      = id_t inside {RR_ALU, STORE};
        dep_ex      = ex_we  && ((use_rs && ex_dst == id_rs)  || (use_rt && ex_dst == id_rt));
        dep_mem     = mem_we && ((use_rs && mem_dst == id_rs) || (use_rt && mem_dst == id_rt));
        if (FWD_EN) begin
            stall_c = id_v && ex_load && dep_ex;
        end else begin
            stall_c = id_v && (dep_ex || dep_mem);
        end
        bubble_ex_c = ex_taken || stall_c;
        halt_id_c   = id_v && (id_t == HALT) && !ex_taken;
        fwd_a_c     = FWD_ID;
        fwd_b_c     = FWD_ID;
        if (FWD_EN) begin
            if (mem_we && mem_dst == ex_rs)     fwd_a_c = FWD_MEM;
            else if (wb_we && wb_dst == ex_rs)  fwd_a_c = FWD_WB;
            if (mem_we && mem_dst == ex_rt)     fwd_b_c = FWD_MEM;
            else if (wb_we && wb_dst == ex_rt)  fwd_b_c = FWD_WB;
        end
    end

endmodule

// File: rtl/mips32_pipe_fwd.sv
// Five-stage MIPS32-subset core with bypassing, load-use interlock, branch flush and internal memory.
module mips32_pipe_fwd
    import mips32_pkg::*;
#(
    parameter int unsigned MEM_AW = 10,
    parameter bit          FWD_EN = 1'b1,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [RAW-1:0]    dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              running,
    output logic              halted,
    output logic [XLEN-1:0]   retire_cnt
);

    localparam int unsigned DEPTH = 2 ** MEM_AW;

    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   rf  [32];

    logic              stop_q;
    logic [MEM_AW-1:0] pc;

    logic              ifid_v;
    logic [XLEN-1:0]   ifid_ir;
    logic [MEM_AW-1:0] ifid_pc;

    logic              idex_v, idex_we;
    instr_t            idex_t;
    logic [OPW-1:0]    idex_op;
    logic [RAW-1:0]    idex_rs, idex_rt, idex_dst;
    logic [XLEN-1:0]   idex_a, idex_b, idex_imm;
    logic [MEM_AW-1:0] idex_pc;

    logic              exmem_v, exmem_we;
    instr_t            exmem_t;
    logic [XLEN-1:0]   exmem_res, exmem_b;
    logic [RAW-1:0]    exmem_dst;

    logic              memwb_v, memwb_we;
    instr_t            memwb_t;
    logic [XLEN-1:0]   memwb_res;
    logic [RAW-1:0]    memwb_dst;

    logic [XLEN-1:0]   if_ir, mem_rdata;
    logic [OPW-1:0]    id_op;
    logic [RAW-1:0]    id_rs, id_rt, id_rd, id_dst;
    logic [XLEN-1:0]   id_imm, id_a, id_b;
    instr_t            id_t;
    logic              id_we;
    logic [XLEN-1:0]   ex_a, ex_b, ex_res;
    logic              ex_taken;
    logic [MEM_AW-1:0] ex_target;
    fwd_sel_t          fwd_a, fwd_b;
    logic              stall, bubble_ex, halt_id;

    // Fetch, load-data and debug read ports; R0 is hardwired to zero.
    assign if_ir     = mem[pc];
    assign mem_rdata = mem[exmem_res[MEM_AW-1:0]];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];

    // Decode; operand reads see a same-cycle writeback.
    assign id_op  = ifid_ir[OP_HI:OP_LO];
    assign id_rs  = ifid_ir[RS_HI:RS_LO];
    assign id_rt  = ifid_ir[RT_HI:RT_LO];
    assign id_rd  = ifid_ir[RD_HI:RD_LO];
    assign id_imm = {{16{ifid_ir[IMM_HI]}}, ifid_ir[IMM_HI:IMM_LO]};
    assign id_t   = decode_type(id_op, MUL_EN);
    assign id_dst = (id_t == RR_ALU) ? id_rd : id_rt;
    assign id_we  = ifid_v && (id_t inside {RR_ALU, RM_ALU, LOAD}) && (id_dst != '0);
    assign id_a   = (id_rs == '0) ? '0 : (memwb_we && memwb_dst == id_rs) ? memwb_res : rf[id_rs];
    assign id_b   = (id_rt == '0) ? '0 : (memwb_we && memwb_dst == id_rt) ? memwb_res : rf[id_rt];

    mips32_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
        .id_v        (ifid_v),
        .id_t        (id_t),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_we       (idex_we),
        .ex_load     (idex_t == LOAD),
        .ex_dst      (idex_dst),
        .ex_rs       (idex_rs),
        .ex_rt       (idex_rt),
        .ex_taken    (ex_taken),
        .mem_we      (exmem_we),
        .mem_dst     (exmem_dst),
        .wb_we       (memwb_we),
        .wb_dst      (memwb_dst),
        .fwd_a_c     (fwd_a),
        .fwd_b_c     (fwd_b),
        .stall_c     (stall),
        .bubble_ex_c (bubble_ex),
        .halt_id_c   (halt_id)
    );

    // Execute: bypassed operands, ALU/address result and branch resolution.
    always_comb begin
        ex_a = (fwd_a == FWD_MEM) ? exmem_res : (fwd_a == FWD_WB) ? memwb_res : idex_a;
        ex_b = (fwd_b == FWD_MEM) ? exmem_res : (fwd_b == FWD_WB) ? memwb_res : idex_b;
        ex_res = ex_a + idex_imm;
        case (idex_op)
            OP_ADD:  ex_res = ex_a + ex_b;
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            OP_OR:   ex_res = ex_a | ex_b;
            OP_SLT:  ex_res = XLEN'($signed(ex_a) < $signed(ex_b));
            OP_MUL:  ex_res = ex_a * ex_b;
            OP_SUBI: ex_res = ex_a - idex_imm;
            OP_SLTI: ex_res = XLEN'($signed(ex_a) < $signed(idex_imm));
            default: ;
        endcase
        ex_taken  = idex_v && (idex_t == BRANCH) &&
                    ((idex_op == OP_BNEQZ) ? (ex_a != '0) : (ex_a == '0));
        ex_target = idex_pc + MEM_AW'(1) + idex_imm[MEM_AW-1:0];
    end

    // Memory and register-file writes; nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && !running && ld_en)
            mem[ld_addr] <= ld_data;
        else if (rst_n && exmem_v && exmem_t == STORE)
            mem[exmem_res[MEM_AW-1:0]] <= exmem_b;
        if (rst_n && memwb_we)
            rf[memwb_dst] <= memwb_res;
    end

    // Run control, PC and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;  halted <= 1'b0;  retire_cnt <= '0;  stop_q <= 1'b0;  pc <= '0;
            ifid_v <= 1'b0;   ifid_ir <= '0;   ifid_pc <= '0;
            idex_v <= 1'b0;   idex_we <= 1'b0; idex_t <= NOP;     idex_op <= '0;
            idex_rs <= '0;    idex_rt <= '0;   idex_dst <= '0;    idex_a <= '0;
            idex_b <= '0;     idex_imm <= '0;  idex_pc <= '0;
            exmem_v <= 1'b0;  exmem_we <= 1'b0; exmem_t <= NOP;   exmem_res <= '0;
            exmem_b <= '0;    exmem_dst <= '0;
            memwb_v <= 1'b0;  memwb_we <= 1'b0; memwb_t <= NOP;   memwb_res <= '0;
            memwb_dst <= '0;
        end else if (start && !running) begin
            running <= 1'b1;  halted <= 1'b0;  retire_cnt <= '0;  stop_q <= 1'b0;  pc <= '0;
            ifid_v <= 1'b0;   idex_v <= 1'b0;  idex_we <= 1'b0;
            exmem_v <= 1'b0;  exmem_we <= 1'b0; memwb_v <= 1'b0;  memwb_we <= 1'b0;
        end else begin
            if (memwb_v) begin
                retire_cnt <= retire_cnt + XLEN'(1);
                if (memwb_t == HALT) begin
                    halted  <= 1'b1;
                    running <= 1'b0;
                end
            end
            memwb_v   <= exmem_v;
            memwb_we  <= exmem_we;
            memwb_t   <= exmem_t;
            memwb_dst <= exmem_dst;
            memwb_res <= (exmem_t == LOAD) ? mem_rdata : exmem_res;

            exmem_v   <= idex_v;
            exmem_we  <= idex_we;
            exmem_t   <= idex_t;
            exmem_dst <= idex_dst;
            exmem_res <= ex_res;
            exmem_b   <= ex_b;

            if (bubble_ex) begin
                idex_v  <= 1'b0;
                idex_we <= 1'b0;
            end else begin
                idex_v   <= ifid_v;
                idex_we  <= id_we;
                idex_t   <= id_t;
                idex_op  <= id_op;
                idex_rs  <= id_rs;
                idex_rt  <= id_rt;
                idex_dst <= id_dst;
                idex_a   <= id_a;
                idex_b   <= id_b;
                idex_imm <= id_imm;
                idex_pc  <= ifid_pc;
            end

            if (ex_taken || halt_id) begin
                ifid_v <= 1'b0;
            end else if (stall) begin
                ifid_v <= ifid_v;
            end else if (running && !stop_q) begin
                ifid_v  <= 1'b1;
                ifid_ir <= if_ir;
                ifid_pc <= pc;
            end else begin
                ifid_v <= 1'b0;
            end

            if (ex_taken)
                pc <= ex_target;
            else if (running && !stop_q && !halt_id && !stall)
                pc <= pc + MEM_AW'(1);

            if (halt_id)
                stop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// Directed bench: runs each program on a bypassing core and a stall-only core side by side.
module tb_mips32_pipe_fwd;

    localparam int AW = 10;

    localparam logic [5:0] ADD = 6'h00, MUL = 6'h05, LW = 6'h08, SW = 6'h09;
    localparam logic [5:0] ADDI = 6'h0A, SUBI = 6'h0B, BNEQZ = 6'h0D, HLT = 6'h3F;

    logic          clk = 1'b0;
    logic          rst_n, start, ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [4:0]    dbg_raddr;
    logic [31:0]   dbg_f, dbg_s, ret_f, ret_s;
    logic          run_f, run_s, hlt_f, hlt_s;

    int total = 0;
    int bad   = 0;
    int cyc_f, cyc_s, fact_cyc, halt_cyc;

    always #5 clk = ~clk;

    mips32_pipe_fwd #(.MEM_AW(AW), .FWD_EN(1'b1), .MUL_EN(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_f), .running(run_f),
        .halted(hlt_f), .retire_cnt(ret_f)
    );

    mips32_pipe_fwd #(.MEM_AW(AW), .FWD_EN(1'b0), .MUL_EN(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_s), .running(run_s),
        .halted(hlt_s), .retire_cnt(ret_s)
    );

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic load(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_halt;
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (run_f) cyc_f++;
            if (run_s) cyc_s++;
            if (hlt_f && hlt_s) done = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_timeout halted=%0b/%0b want=1/1", hlt_f, hlt_s);
        end
    endtask

    task automatic run_prog;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc_f = 0; cyc_s = 0;
        wait_halt();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;
        repeat (2) @(negedge clk);
        total++;
        if (run_f !== 1'b0 || run_s !== 1'b0) begin
            bad++; $display("FAIL reset_running got=%0b/%0b want=0", run_f, run_s);
        end
        total++;
        if (hlt_f !== 1'b0 || hlt_s !== 1'b0) begin
            bad++; $display("FAIL reset_halted got=%0b/%0b want=0", hlt_f, hlt_s);
        end
        total++;
        if (ret_f !== 32'd0 || ret_s !== 32'd0) begin
            bad++; $display("FAIL reset_retire got=%0d/%0d want=0", ret_f, ret_s);
        end
        total++;
        if (dut_f.pc !== 10'd0 || dut_s.pc !== 10'd0) begin
            bad++; $display("FAIL reset_pc got=%0d/%0d want=0", dut_f.pc, dut_s.pc);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_chain;
        load(0, enc_i(ADDI, 0, 1, 10));
        load(1, enc_i(ADDI, 0, 2, 20));
        load(2, enc_i(ADDI, 0, 3, 25));
        load(3, enc_r(ADD, 1, 2, 4));
        load(4, enc_r(ADD, 4, 3, 5));
        load(5, {HLT, 26'd0});
        run_prog();
        dbg_raddr = 5'd4; #1;
        total++;
        if (dbg_f !== 32'd30 || dbg_s !== 32'd30) begin
            bad++; $display("FAIL chain_r4 got=%0d/%0d want=30", dbg_f, dbg_s);
        end
        dbg_raddr = 5'd5; #1;
        total++;
        if (dbg_f !== 32'd55 || dbg_s !== 32'd55) begin
            bad++; $display("FAIL chain_r5 got=%0d/%0d want=55", dbg_f, dbg_s);
        end
        total++;
        if (ret_f !== 32'd6 || ret_s !== 32'd6 || hlt_f !== 1'b1 || run_f !== 1'b0) begin
            bad++; $display("FAIL chain_retire got=%0d/%0d halted=%0b want=6 halted=1", ret_f, ret_s, hlt_f);
        end
        total++;
        if (cyc_f != 10) begin
            bad++; $display("FAIL chain_cycles got=%0d want=10", cyc_f);
        end
        total++;
        if (cyc_s <= cyc_f) begin
            bad++; $display("FAIL chain_nofwd_slower got=%0d want>%0d", cyc_s, cyc_f);
        end
    endtask

    task automatic test_load_use;
        load(120, 32'd85);
        load(121, 32'd0);
        load(0, enc_i(ADDI, 0, 1, 120));
        load(1, enc_i(LW, 1, 2, 0));
        load(2, enc_i(ADDI, 2, 2, 45));
        load(3, enc_i(SW, 1, 2, 1));
        load(4, {HLT, 26'd0});
        run_prog();
        total++;
        if (dut_f.mem[121] !== 32'd130 || dut_s.mem[121] !== 32'd130) begin
            bad++; $display("FAIL lduse_mem121 got=%0d/%0d want=130", dut_f.mem[121], dut_s.mem[121]);
        end
        total++;
        if (ret_f !== 32'd5 || ret_s !== 32'd5) begin
            bad++; $display("FAIL lduse_retire got=%0d/%0d want=5", ret_f, ret_s);
        end
        total++;
        if (cyc_f != 10) begin
            bad++; $display("FAIL lduse_one_stall_cycles got=%0d want=10", cyc_f);
        end
        total++;
        if (cyc_s <= cyc_f) begin
            bad++; $display("FAIL lduse_nofwd_slower got=%0d want>%0d", cyc_s, cyc_f);
        end
    endtask

    task automatic load_factorial;
        load(0, enc_i(ADDI, 0, 10, 200));
        load(1, enc_i(ADDI, 0, 2, 1));
        load(2, enc_i(LW, 10, 3, 0));
        load(3, enc_r(MUL, 2, 3, 2));
        load(4, enc_i(SUBI, 3, 3, 1));
        load(5, enc_i(BNEQZ, 3, 0, -3));
        load(6, enc_i(SW, 10, 2, -2));
        load(7, {HLT, 26'd0});
    endtask

    task automatic test_factorial;
        load(200, 32'd7);
        load(198, 32'd0);
        load_factorial();
        run_prog();
        fact_cyc = cyc_f;
        total++;
        if (dut_f.mem[198] !== 32'd5040 || dut_s.mem[198] !== 32'd5040) begin
            bad++; $display("FAIL fact_mem198 got=%0d/%0d want=5040", dut_f.mem[198], dut_s.mem[198]);
        end
        dbg_raddr = 5'd3; #1;
        total++;
        if (dbg_f !== 32'd0 || dbg_s !== 32'd0) begin
            bad++; $display("FAIL fact_r3 got=%0d/%0d want=0", dbg_f, dbg_s);
        end
        total++;
        if (ret_f !== 32'd26 || ret_s !== 32'd26) begin
            bad++; $display("FAIL fact_retire got=%0d/%0d want=26", ret_f, ret_s);
        end
        total++;
        if (cyc_s <= cyc_f) begin
            bad++; $display("FAIL fact_nofwd_slower got=%0d want>%0d", cyc_s, cyc_f);
        end
    endtask

    task automatic test_reset_mid_run;
        load(198, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (run_f !== 1'b0 || hlt_f !== 1'b0 || ret_f !== 32'd0 || dut_f.pc !== 10'd0 ||
            run_s !== 1'b0 || hlt_s !== 1'b0 || ret_s !== 32'd0 || dut_s.pc !== 10'd0) begin
            bad++; $display("FAIL midreset_state run=%0b/%0b halt=%0b/%0b ret=%0d/%0d pc=%0d/%0d want all 0",
                            run_f, run_s, hlt_f, hlt_s, ret_f, ret_s, dut_f.pc, dut_s.pc);
        end
        @(negedge clk);
        total++;
        if (dut_f.mem[198] !== 32'd0 || dut_s.mem[198] !== 32'd0 || run_f !== 1'b0) begin
            bad++; $display("FAIL midreset_aborted mem198=%0d/%0d run=%0b want=0", dut_f.mem[198], dut_s.mem[198], run_f);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_prog();
        total++;
        if (dut_f.mem[198] !== 32'd5040 || dut_s.mem[198] !== 32'd5040 || ret_f !== 32'd26) begin
            bad++; $display("FAIL midreset_rerun mem198=%0d/%0d ret=%0d want=5040 ret=26", dut_f.mem[198], dut_s.mem[198], ret_f);
        end
    endtask

    task automatic test_start_ld_ignored;
        load(100, 32'h1234);
        load(198, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; ld_en = 1'b1; ld_addr = AW'(100); ld_data = 32'hdead;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        cyc_f = 7; cyc_s = 7;
        wait_halt();
        total++;
        if (cyc_f != fact_cyc) begin
            bad++; $display("FAIL busy_start_cycles got=%0d want=%0d", cyc_f, fact_cyc);
        end
        total++;
        if (dut_f.mem[100] !== 32'h1234 || dut_s.mem[100] !== 32'h1234) begin
            bad++; $display("FAIL busy_ld_mem100 got=%h/%h want=1234", dut_f.mem[100], dut_s.mem[100]);
        end
        total++;
        if (dut_f.mem[198] !== 32'd5040 || ret_f !== 32'd26 || ret_s !== 32'd26) begin
            bad++; $display("FAIL busy_result mem198=%0d ret=%0d/%0d want=5040 ret=26", dut_f.mem[198], ret_f, ret_s);
        end
    endtask

    task automatic test_load_with_start;
        load(198, 32'd0);
        ld_en = 1'b1; ld_addr = AW'(200); ld_data = 32'd5; start = 1'b1;
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0;
        cyc_f = 0; cyc_s = 0;
        wait_halt();
        total++;
        if (dut_f.mem[198] !== 32'd120 || dut_s.mem[198] !== 32'd120) begin
            bad++; $display("FAIL ldstart_mem198 got=%0d/%0d want=120", dut_f.mem[198], dut_s.mem[198]);
        end
        total++;
        if (ret_f !== 32'd20 || ret_s !== 32'd20) begin
            bad++; $display("FAIL ldstart_retire got=%0d/%0d want=20", ret_f, ret_s);
        end
    endtask

    task automatic test_r0_halt;
        load(0, enc_i(ADDI, 0, 7, 77));
        load(1, enc_i(ADDI, 0, 6, 9));
        load(2, {HLT, 26'd0});
        run_prog();
        dbg_raddr = 5'd6; #1;
        total++;
        if (dbg_f !== 32'd9 || dbg_s !== 32'd9) begin
            bad++; $display("FAIL r0_prep_r6 got=%0d/%0d want=9", dbg_f, dbg_s);
        end
        load(0, enc_i(ADDI, 0, 0, 5));
        load(1, enc_r(ADD, 0, 0, 6));
        load(2, {HLT, 26'd0});
        load(3, enc_i(ADDI, 0, 7, 1));
        for (int pass = 0; pass < 2; pass++) begin
            run_prog();
            halt_cyc = cyc_f;
            dbg_raddr = 5'd0; #1;
            total++;
            if (dbg_f !== 32'd0 || dbg_s !== 32'd0) begin
                bad++; $display("FAIL r0_read pass=%0d got=%0d/%0d want=0", pass, dbg_f, dbg_s);
            end
            dbg_raddr = 5'd6; #1;
            total++;
            if (dbg_f !== 32'd0 || dbg_s !== 32'd0) begin
                bad++; $display("FAIL r0_r6 pass=%0d got=%0d/%0d want=0", pass, dbg_f, dbg_s);
            end
            dbg_raddr = 5'd7; #1;
            total++;
            if (dbg_f !== 32'd77 || dbg_s !== 32'd77) begin
                bad++; $display("FAIL halt_r7_unchanged pass=%0d got=%0d/%0d want=77", pass, dbg_f, dbg_s);
            end
            total++;
            if (ret_f !== 32'd3 || ret_s !== 32'd3 || hlt_f !== 1'b1 || halt_cyc != 7) begin
                bad++; $display("FAIL halt_rerun pass=%0d ret=%0d/%0d halted=%0b cycles=%0d want ret=3 halted=1 cycles=7",
                                pass, ret_f, ret_s, hlt_f, halt_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_factorial();
        test_reset_mid_run();
        test_start_ld_ignored();
        test_load_with_start();
        test_r0_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
